conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, pixel word width (raw bits, no arithmetic applied).
REQ-002 SHALL have parameter IMG_W, default 32, input image columns.
REQ-003 SHALL have parameter IMG_H, default 32, input image rows.
REQ-004 SHALL have parameter K, default 5, square window size; output grid is (IMG_H-K+1) x (IMG_W-K+1), i.e. 28x28 by default.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port in_data  input  DATA_W  pixel, raster order (row-major, column fastest).
REQ-008 SHALL have port in_valid  input  1  in_data is valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port out_win  output  K*K*DATA_W  window; tap t = r*K+c in bits [t*DATA_W +: DATA_W] = pixel (out_row+r, out_col+c); tap 0 is top-left, maps directly to the MAC unit's input0..input24.
REQ-011 SHALL have port out_valid  output  1  out_win/out_row/out_col are valid.
REQ-012 SHALL have port out_ready  input  1  downstream consumes the window this cycle.
REQ-013 SHALL have port out_row  output  $clog2(IMG_H)  window top row index.
REQ-014 SHALL have port out_col  output  $clog2(IMG_W)  window left column index.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse when the last window of a frame is consumed.

Function
REQ-016 SHALL accept a pixel only when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no other stall source).
REQ-017 SHALL keep K-1 line buffers of IMG_W words each, plus a KxK register window; each accepted pixel shifts the window left one column and loads a new right column from the line-buffer outputs and in_data.
REQ-018 SHALL track in_col (0..IMG_W-1) and in_row (0..IMG_H-1) of the next pixel; in_col wraps to 0 and in_row increments at IMG_W-1; in_row wraps to 0 after IMG_H-1 (next frame starts at pixel 0, no gap cycle).
REQ-019 SHALL set out_valid on the cycle after accepting a pixel with in_row >= K-1 and in_col >= K-1; out_row = in_row-(K-1), out_col = in_col-(K-1) of that pixel.
REQ-020 SHALL not emit windows straddling a row boundary (in_col < K-1 produces no window).
REQ-021 SHALL hold out_win, out_row, out_col, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL clear out_valid after out_ready when the same-cycle accepted pixel produces no window; SHALL load the new window with no bubble when it does.
REQ-023 SHALL pulse frame_done for one cycle after consumption of window (IMG_H-K, IMG_W-K); exactly (IMG_H-K+1)*(IMG_W-K+1) windows per frame.
REQ-024 Latency: accept-to-out_valid = 1 cycle; sustained throughput 1 pixel/cycle with out_ready held high.

Reset
REQ-025 On rst_n low: in_col, in_row = 0; out_valid = 0; frame_done = 0; out_row, out_col = 0; window registers = 0; in_ready = 1 after release.
REQ-026 Line-buffer storage need not be reset; reset mid-frame discards the partial frame and the next accepted pixel is pixel (0,0).

Structure
REQ-027 SHALL place DATA_W, IMG_W, IMG_H, K defaults and derived OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1 in shared package conv_pkg.
REQ-028 SHALL instantiate K-1 copies of sub-module line_buffer (IMG_W-deep delay line, shift-enable, DATA_W wide, no reset on storage).

Verification
REQ-029 Ramp 32x32 frame (pixel = row*32+col), out_ready=1 -> first window out_row=0,out_col=0, tap t = (t/5)*32 + t%5; 784 windows; frame_done once.
REQ-030 Same frame, pixel index 131 (row 4, col 3) accepted -> no out_valid; pixel 132 accepted -> out_valid next cycle, window (0,0).
REQ-031 out_ready low for 10 cycles mid-row -> in_ready low, out_win/out_row/out_col unchanged, no window lost or duplicated.
REQ-032 Two back-to-back frames, in_valid held high -> 1568 windows, second frame window (0,0) taps equal first frame's, frame_done pulses twice.
REQ-033 rst_n low at pixel 500 for 2 cycles, then full frame -> out_valid 0 during reset, then exactly 784 correct windows.
REQ-034 Random in_valid/out_ready toggling (50%) over 3 frames -> windows match software 5x5 sliding reference, in order.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared configuration for the sliding-window generator: default image and
// window geometry, the derived output grid size, and tap indexing.
package conv_pkg;

  localparam int DATA_W = 32;
  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int K      = 5;
  localparam int OUT_W  = IMG_W - K + 1;
  localparam int OUT_H  = IMG_H - K + 1;

  // Flat tap number of window element (row, col); tap 0 is the top-left pixel.
  function automatic int tap_index(input int row, input int col, input int k);
    return row * k + col;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Fixed-length delay line: the word presented on data_o is the word that was
// written DEPTH shift-enables ago. Built as a circular buffer so only one
// entry is written per shift. Storage is not reset; only the pointer is.
module line_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // The oldest entry sits at the write pointer and is read before overwrite.
  assign data_o = mem_q[ptr_q];

  // Advance the circular pointer on every shift, wrapping after DEPTH entries.
  always_comb begin
    ptr_d = ptr_q;
    if (shift_en_i) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) begin
        ptr_d = {PTR_W{1'b0}};
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= {PTR_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage write; contents carry no reset.
  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      mem_q[ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Raster-scan KxK sliding-window generator. K-1 line buffers supply the
// vertical neighbours of each incoming pixel; a KxK register window shifts
// left on every accepted pixel. A window is presented whenever the accepted
// pixel completes a full KxK block within one image, with a single-entry
// valid/ready output stage that back-pressures the pixel input directly.
module conv_window_gen #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int IMG_W  = conv_pkg::IMG_W,
  parameter int IMG_H  = conv_pkg::IMG_H,
  parameter int K      = conv_pkg::K
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [K*K*DATA_W-1:0]      out_win,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       frame_done
);

  import conv_pkg::*;

  localparam int ROW_W    = $clog2(IMG_H);
  localparam int COL_W    = $clog2(IMG_W);
  localparam int WIN_W    = K * K * DATA_W;
  localparam int OUT_ROWS = IMG_H - K + 1;
  localparam int OUT_COLS = IMG_W - K + 1;

  logic [COL_W-1:0]  in_col_q,     in_col_d;
  logic [ROW_W-1:0]  in_row_q,     in_row_d;
  logic [WIN_W-1:0]  win_q,        win_d;
  logic              out_valid_q,  out_valid_d;
  logic [ROW_W-1:0]  out_row_q,    out_row_d;
  logic [COL_W-1:0]  out_col_q,    out_col_d;
  logic              frame_done_q, frame_done_d;

  logic              accept_s;
  logic              win_hit_s;
  logic [DATA_W-1:0] lb_out_s [K-1];
  logic [DATA_W-1:0] col_s    [K];

  // The output stage is the only stall source: take a pixel whenever the
  // current window is absent or leaving this cycle.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign win_hit_s = (in_row_q >= ROW_W'(K - 1)) && (in_col_q >= COL_W'(K - 1));

  // Cascade of line buffers: buffer j outputs the pixel j+1 rows above in_data.
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    logic [DATA_W-1:0] lb_in_s;
    if (j == 0) begin : g_first
      assign lb_in_s = in_data;
    end else begin : g_chain
      assign lb_in_s = lb_out_s[j-1];
    end
    line_buffer #(
      .DEPTH (IMG_W),
      .WIDTH (DATA_W)
    ) u_line_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .shift_en_i (accept_s),
      .data_i     (lb_in_s),
      .data_o     (lb_out_s[j])
    );
  end

  // Assemble the new right-hand column: oldest row at the top, in_data at the bottom.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      col_s[r] = {DATA_W{1'b0}};
    end
    for (int r = 0; r < K - 1; r++) begin
      col_s[r] = lb_out_s[K-2-r];
    end
    col_s[K-1] = in_data;
  end

  // Next-state: window shift, raster position counters and output handshake.
  always_comb begin
    win_d        = win_q;
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    out_valid_d  = out_valid_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_done_d = out_valid_q && out_ready &&
                   (out_row_q == ROW_W'(OUT_ROWS - 1)) &&
                   (out_col_q == COL_W'(OUT_COLS - 1));
    if (accept_s) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          if (c < K - 1) begin
            win_d[tap_index(r, c, K)*DATA_W +: DATA_W] = win_q[tap_index(r, c + 1, K)*DATA_W +: DATA_W];
          end else begin
            win_d[tap_index(r, c, K)*DATA_W +: DATA_W] = col_s[r];
          end
        end
      end
      if (in_col_q == COL_W'(IMG_W - 1)) begin
        in_col_d = {COL_W{1'b0}};
        if (in_row_q == ROW_W'(IMG_H - 1)) begin
          in_row_d = {ROW_W{1'b0}};
        end else begin
          in_row_d = in_row_q + ROW_W'(1);
        end
      end else begin
        in_col_d = in_col_q + COL_W'(1);
      end
      out_valid_d = win_hit_s;
      if (win_hit_s) begin
        out_row_d = in_row_q - ROW_W'(K - 1);
        out_col_d = in_col_q - COL_W'(K - 1);
      end else begin
        out_row_d = out_row_q;
        out_col_d = out_col_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q        <= {WIN_W{1'b0}};
      in_col_q     <= {COL_W{1'b0}};
      in_row_q     <= {ROW_W{1'b0}};
      out_valid_q  <= 1'b0;
      out_row_q    <= {ROW_W{1'b0}};
      out_col_q    <= {COL_W{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      win_q        <= win_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_win    = win_q;
  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen at default geometry (32x32 image, 5x5 window).
// Pixels are driven and outputs sampled on the falling clock edge; expected
// windows come from a per-frame software sliding-window table.
module tb_conv_window_gen;

  localparam int DW    = 32;
  localparam int IW    = 32;
  localparam int IH    = 32;
  localparam int KW    = 5;
  localparam int OW    = IW - KW + 1;
  localparam int OH    = IH - KW + 1;
  localparam int WIN_W = KW * KW * DW;
  localparam int NPIX  = IW * IH;

  typedef struct {
    logic [4:0]       row;
    logic [4:0]       col;
    logic [WIN_W-1:0] win;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIN_W-1:0] out_win;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_row;
  logic [4:0]       out_col;
  logic             frame_done;

  conv_window_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_win    (out_win),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [DW-1:0]    pix_q [$];
  exp_t             exp_q [$];
  int               acc;
  int               win_cnt;
  int               fd_cnt;
  bit               mv;
  bit               fd_exp;
  bit               hold_valid;
  logic [WIN_W-1:0] hold_win;
  logic [4:0]       hold_row;
  logic [4:0]       hold_col;

  task automatic check(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pv(input int fid, input int r, input int c);
    logic [DW-1:0] v;
    v = DW'(fid * 65536 + r * IW + c);
    return v;
  endfunction

  task automatic load_frame(input int fid);
    exp_t e;
    for (int i = 0; i < NPIX; i++) pix_q.push_back(pv(fid, i / IW, i % IW));
    for (int orow = 0; orow < OH; orow++) begin
      for (int ocol = 0; ocol < OW; ocol++) begin
        e.row = 5'(orow);
        e.col = 5'(ocol);
        e.win = '0;
        for (int t = 0; t < KW * KW; t++) e.win[t*DW +: DW] = pv(fid, orow + t / KW, ocol + t % KW);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic clear_model();
    pix_q.delete();
    exp_q.delete();
    acc = 0; win_cnt = 0; fd_cnt = 0;
    mv = 1'b0; fd_exp = 1'b0; hold_valid = 1'b0;
  endtask

  task automatic step(input bit iv, input bit ordy);
    exp_t e;
    int   r, c;
    @(negedge clk);
    in_valid = iv && (pix_q.size() != 0);
    if (pix_q.size() != 0) in_data = pix_q[0];
    else in_data = '0;
    out_ready = ordy;
    #1;
    check("in_ready", WIN_W'(in_ready), WIN_W'(!out_valid || out_ready));
    check("out_valid", WIN_W'(out_valid), WIN_W'(mv));
    check("frame_done", WIN_W'(frame_done), WIN_W'(fd_exp));
    if (frame_done) fd_cnt++;
    if (hold_valid) begin
      check("hold_win", out_win, hold_win);
      check("hold_row", WIN_W'(out_row), WIN_W'(hold_row));
      check("hold_col", WIN_W'(out_col), WIN_W'(hold_col));
    end
    fd_exp = 1'b0;
    hold_valid = 1'b0;
    if (out_valid && out_ready) begin
      win_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_window", WIN_W'(1), WIN_W'(0));
      end else begin
        e = exp_q.pop_front();
        check("win_row", WIN_W'(out_row), WIN_W'(e.row));
        check("win_col", WIN_W'(out_col), WIN_W'(e.col));
        check("win_taps", out_win, e.win);
        if (e.row == 5'(OH - 1) && e.col == 5'(OW - 1)) fd_exp = 1'b1;
      end
    end else if (out_valid) begin
      hold_valid = 1'b1;
      hold_win = out_win;
      hold_row = out_row;
      hold_col = out_col;
    end
    if (in_valid && in_ready) begin
      r = (acc % NPIX) / IW;
      c = acc % IW;
      mv = (r >= KW - 1) && (c >= KW - 1);
      void'(pix_q.pop_front());
      acc++;
    end else if (out_ready) begin
      mv = 1'b0;
    end
  endtask

  task automatic run(input bit rnd, input int stall_at, input int limit, input int budget);
    int stall_cnt;
    bit iv, ordy;
    stall_cnt = 0;
    while ((pix_q.size() != 0 || exp_q.size() != 0) && acc < limit && budget > 0) begin
      if (rnd) begin
        iv   = 1'($urandom_range(0, 1));
        ordy = 1'($urandom_range(0, 1));
      end else begin
        iv = 1'b1;
        ordy = 1'b1;
        if (acc >= stall_at && stall_cnt < 10) begin
          ordy = 1'b0;
          stall_cnt++;
        end
      end
      step(iv, ordy);
      budget--;
    end
    if (budget == 0) check("timeout", WIN_W'(1), WIN_W'(0));
  endtask

  task automatic idle_tail();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, WIN_W'(out_valid), WIN_W'(0));
    check({tag, "_frame_done"}, WIN_W'(frame_done), WIN_W'(0));
    check({tag, "_out_row"}, WIN_W'(out_row), WIN_W'(0));
    check({tag, "_out_col"}, WIN_W'(out_col), WIN_W'(0));
    check({tag, "_out_win"}, out_win, WIN_W'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", WIN_W'(in_ready), WIN_W'(1));

    // Ramp frame with a 10-cycle output stall mid-row.
    clear_model();
    load_frame(0);
    run(1'b0, 200, 1 << 30, 5000);
    idle_tail();
    check("ramp_windows", WIN_W'(win_cnt), WIN_W'(OW * OH));
    check("ramp_frame_done", WIN_W'(fd_cnt), WIN_W'(1));

    // Two back-to-back ramp frames with no gap.
    clear_model();
    load_frame(0);
    load_frame(0);
    run(1'b0, 1 << 30, 1 << 30, 5000);
    idle_tail();
    check("b2b_windows", WIN_W'(win_cnt), WIN_W'(2 * OW * OH));
    check("b2b_frame_done", WIN_W'(fd_cnt), WIN_W'(2));

    // Reset after 500 pixels, then a clean frame.
    clear_model();
    load_frame(0);
    run(1'b0, 1 << 30, 500, 5000);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs("midrst0");
    @(negedge clk);
    #1;
    check_reset_outputs("midrst1");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", WIN_W'(in_ready), WIN_W'(1));
    clear_model();
    load_frame(0);
    run(1'b0, 1 << 30, 1 << 30, 5000);
    idle_tail();
    check("postrst_windows", WIN_W'(win_cnt), WIN_W'(OW * OH));
    check("postrst_frame_done", WIN_W'(fd_cnt), WIN_W'(1));

    // Three distinct frames under random input/output handshakes.
    clear_model();
    load_frame(1);
    load_frame(2);
    load_frame(3);
    run(1'b1, 1 << 30, 1 << 30, 60000);
    idle_tail();
    check("rand_windows", WIN_W'(win_cnt), WIN_W'(3 * OW * OH));
    check("rand_frame_done", WIN_W'(fd_cnt), WIN_W'(3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
